// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    NORM = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned MEM_DEPTH_DEFAULT  = 1024;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating count of consecutive cycles the debug port was refused; at_max forces its grant.
module dmem_starve_counter #(
  parameter int unsigned MAX_CNT = 4,
  parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MaxVal);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (priority) and the debug/loader
// port, with starvation relief, exclusive lock mode and an out-of-range address guard.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEFAULT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(MEM_DEPTH);

  arb_state_e state_q, state_d;
  logic       starve_max;
  logic       cpu_in_range, dbg_in_range;
  logic       cpu_go;

  logic              rvalid_q, err_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NORM;
    end else begin
      state_q <= state_d;
    end
  end

  // The cycle lock first rises is still arbitrated as NORM; the switch takes effect next edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORM:    if (dbg_lock) state_d = LOCK;
      LOCK:    if (!dbg_lock) state_d = NORM;
      default: state_d = NORM;
    endcase
  end

  always_comb begin
    dbg_gnt   = dbg_req & ((state_q == LOCK) | ~cpu_req | starve_max);
    cpu_stall = cpu_req & ((state_q == LOCK) | dbg_gnt);
    cpu_go    = cpu_req & ~cpu_stall;
  end

  dmem_starve_counter #(
    .MAX_CNT(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clr   (dbg_gnt | ~dbg_req),
    .inc   (dbg_req & cpu_req & ~dbg_gnt),
    .at_max(starve_max)
  );

  assign cpu_in_range = (cpu_addr < DepthA);
  assign dbg_in_range = (dbg_addr < DepthA);

  // CPU owns the address bus whenever the debug port is not granted.
  always_comb begin
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we & dbg_in_range;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_go & cpu_we & cpu_in_range;
    end
  end

  assign cpu_rdata = cpu_in_range ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= dbg_gnt & ~dbg_we;
      err_q    <= dbg_gnt & ~dbg_in_range;
      if (dbg_gnt && !dbg_we) begin
        rdata_q <= dbg_in_range ? mem_rdata : '0;
      end
    end
  end

  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;
  assign dbg_err    = err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, then randomized traffic vs a model.
module tb_dmem_port_arbiter;

  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 1024;

  logic        clk, rst;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  dmem_port_arbiter #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .MEM_DEPTH (DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_lock  (dbg_lock),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .dbg_err   (dbg_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory; out-of-range reads return garbage so the guard is observable.
  logic [31:0] mem [DEPTH] = '{default: '0};
  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[9:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        stall, gnt, we, chk_rd;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic cr, input logic cw, input logic [31:0] ca,
                              input logic [31:0] cd, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dd,
                              input logic stall, input logic gnt, input logic we,
                              input logic chk_rd, input logic [31:0] rd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.stall = stall; v.gnt = gnt; v.we = we; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setin(input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic lk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = lk;
  endtask

  // Apply inputs just after a rising edge and return at the following falling edge.
  task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca,
                     input logic [31:0] cd, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd, input logic lk);
    @(posedge clk);
    #1;
    setin(cr, cw, ca, cd, dr, dw, da, dd, lk);
    @(negedge clk);
  endtask

  vec_t tbl [11];

  // Reference model state
  logic [31:0] ref_mem [DEPTH] = '{default: '0};
  bit          m_lock;
  int          m_streak;
  bit          exp_rv, exp_err;
  logic [31:0] exp_rd;

  initial begin
    tbl[0]  = mk(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 32,   'h55,  0, 0, 0,    0,     0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 32,   0,     0, 0, 0,    0,     0, 0, 0, 1, 'h55);
    tbl[3]  = mk(0, 0, 0,    0,     1, 1, 33,   'hA5,  0, 1, 1, 0, 0);
    tbl[4]  = mk(1, 0, 33,   0,     1, 0, 40,   0,     0, 0, 0, 1, 'hA5);
    tbl[5]  = mk(0, 0, 0,    0,     1, 1, 1024, 'hBAD, 0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 1, 2000, 'h77,  0, 0, 0,    0,     0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 2000, 0,     0, 0, 0,    0,     0, 0, 0, 1, 0);
    tbl[8]  = mk(1, 1, 1023, 'h1234, 0, 0, 0,   0,     0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 0, 1023, 0,     0, 0, 0,    0,     0, 0, 0, 1, 'h1234);
    tbl[10] = mk(1, 1, 34,   'h66,  1, 1, 40,   'h99,  0, 0, 1, 0, 0);

    rst = 1'b1;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rvalid", 32'(dbg_rvalid), 0);
    chk("reset_rdata", dbg_rdata, 0);
    chk("reset_err", 32'(dbg_err), 0);
    chk("reset_gnt_idle", 32'(dbg_gnt), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
          tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd, 1'b0);
      chk($sformatf("row%0d_stall", i), 32'(cpu_stall), 32'(tbl[i].stall));
      chk($sformatf("row%0d_gnt", i), 32'(dbg_gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
      if (tbl[i].chk_rd) chk($sformatf("row%0d_cpu_rdata", i), cpu_rdata, tbl[i].rd);
    end

    // Reset asserted in the cycle a DBG read is granted (with lock requested).
    cyc(0, 0, 0, 0, 1, 0, 33, 0, 1);
    chk("rstrd_gnt", 32'(dbg_gnt), 1);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstrd_rvalid_in_reset", 32'(dbg_rvalid), 0);
    rst = 1'b0;
    setin(1, 0, 32, 0, 1, 0, 33, 0, 0);
    @(negedge clk);
    chk("rstrd_norm_gnt", 32'(dbg_gnt), 0);
    chk("rstrd_norm_stall", 32'(cpu_stall), 0);
    chk("rstrd_rvalid", 32'(dbg_rvalid), 0);

    // Continuous contention: DBG forced in on the fifth cycle only.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      cyc(1, 0, 32, 0, 1, 0, 33, 0, 0);
      chk($sformatf("cont%0d_gnt", c), 32'(dbg_gnt), 32'(c == 5));
      chk($sformatf("cont%0d_stall", c), 32'(cpu_stall), 32'(c == 5));
      if (c != 5) chk($sformatf("cont%0d_cpu_rdata", c), cpu_rdata, 'h55);
    end
    chk("cont_rvalid", 32'(dbg_rvalid), 1);
    chk("cont_rdata", dbg_rdata, 'hA5);

    // DBG reads with CPU idle, back to back.
    cyc(0, 0, 0, 0, 1, 0, 33, 0, 0);
    chk("dbgrd_gnt", 32'(dbg_gnt), 1);
    cyc(0, 0, 0, 0, 1, 0, 32, 0, 0);
    chk("dbgrd2_gnt", 32'(dbg_gnt), 1);
    chk("dbgrd_rvalid", 32'(dbg_rvalid), 1);
    chk("dbgrd_rdata", dbg_rdata, 'hA5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("dbgrd2_rvalid", 32'(dbg_rvalid), 1);
    chk("dbgrd2_rdata", dbg_rdata, 'h55);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("dbgrd_rvalid_end", 32'(dbg_rvalid), 0);

    // Out-of-range accesses.
    cyc(0, 0, 0, 0, 1, 1, 1024, 'hBAD, 0);
    chk("oob_wr_gnt", 32'(dbg_gnt), 1);
    chk("oob_wr_mem_we", 32'(mem_we), 0);
    cyc(1, 0, 2000, 0, 0, 0, 0, 0, 0);
    chk("oob_wr_err", 32'(dbg_err), 1);
    chk("oob_wr_rvalid", 32'(dbg_rvalid), 0);
    chk("oob_cpu_rdata", cpu_rdata, 0);
    cyc(0, 0, 0, 0, 1, 0, 1500, 0, 0);
    chk("oob_err_pulse", 32'(dbg_err), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("oob_rd_err", 32'(dbg_err), 1);
    chk("oob_rd_rvalid", 32'(dbg_rvalid), 1);
    chk("oob_rd_rdata", dbg_rdata, 0);

    // Lock held 10 cycles with CPU requesting throughout; DBG writes 0..7.
    for (int c = 1; c <= 12; c++) begin
      bit dr;
      dr = (c >= 2) && (c <= 9);
      cyc(1, 0, 32, 0, dr, 1, 32'(c - 2), 32'('h100 + c - 2), c <= 10);
      chk($sformatf("lock%0d_stall", c), 32'(cpu_stall), 32'((c >= 2) && (c <= 11)));
      chk($sformatf("lock%0d_gnt", c), 32'(dbg_gnt), 32'(dr));
      if (c == 1 || c == 12) chk($sformatf("lock%0d_cpu_rdata", c), cpu_rdata, 'h55);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("lock_mem%0d", i), mem[i], 32'('h100 + i));

    // Randomized traffic against the reference model (addresses 64..79 plus out-of-range).
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_lock = 0; m_streak = 0; exp_rv = 0; exp_err = 0; exp_rd = '0;
    begin
      logic        cr, cw, dr, dw, lk, gnt_e, stall_e, we_e, inr_c, inr_d;
      logic [31:0] ca, cd, da, dd;
      dr = 0; dw = 0; da = 0; dd = 0; lk = 0; gnt_e = 1;
      for (int n = 0; n < 500; n++) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = $urandom_range(0, 1) == 1;
        ca = ($urandom_range(0, 7) == 0) ? 32'(1024 + $urandom_range(0, 5000))
                                         : 32'(64 + $urandom_range(0, 15));
        cd = $urandom;
        if (!(dr && !gnt_e)) begin
          dr = $urandom_range(0, 1) == 1;
          dw = $urandom_range(0, 1) == 1;
          da = ($urandom_range(0, 7) == 0) ? 32'(1024 + $urandom_range(0, 5000))
                                           : 32'(64 + $urandom_range(0, 15));
          dd = $urandom;
        end
        if ($urandom_range(0, 11) == 0) lk = !lk;
        @(posedge clk);
        #1;
        setin(cr, cw, ca, cd, dr, dw, da, dd, lk);
        @(negedge clk);
        inr_c   = ca < 32'(DEPTH);
        inr_d   = da < 32'(DEPTH);
        gnt_e   = dr && (m_lock || !cr || m_streak >= STARVE_MAX);
        stall_e = cr && (m_lock || gnt_e);
        we_e    = gnt_e ? (dw && inr_d) : (cr && !stall_e && cw && inr_c);
        chk("rnd_gnt", 32'(dbg_gnt), 32'(gnt_e));
        chk("rnd_stall", 32'(cpu_stall), 32'(stall_e));
        chk("rnd_mem_we", 32'(mem_we), 32'(we_e));
        if (cr && !stall_e && !cw) chk("rnd_cpu_rdata", cpu_rdata, inr_c ? ref_mem[ca[9:0]] : 0);
        chk("rnd_rvalid", 32'(dbg_rvalid), 32'(exp_rv));
        if (exp_rv) chk("rnd_dbg_rdata", dbg_rdata, exp_rd);
        chk("rnd_err", 32'(dbg_err), 32'(exp_err));
        exp_rv  = gnt_e && !dw;
        exp_rd  = inr_d ? ref_mem[da[9:0]] : 0;
        exp_err = gnt_e && !inr_d;
        if (we_e) begin
          if (gnt_e) ref_mem[da[9:0]] = dd;
          else ref_mem[ca[9:0]] = cd;
        end
        m_streak = (dr && !gnt_e) ? m_streak + 1 : 0;
        m_lock   = lk;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
